// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit : iterative shift-add multiply / restoring divide for HI/LO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic                 is_div_q, is_div_d, dz_q, dz_d;
  logic                 done_q, done_d, dzo_q, dzo_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       add_sum, rem_sh, sub_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 last_iter;

  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign sub_diff  = rem_sh - {1'b0, opnd_q};
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dzo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d  = MULT;
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, mag_b};
          opnd_d   = mag_a;
          neg_lo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_hi_d = 1'b0;
          is_div_d = 1'b0;
          dz_d     = 1'b0;
        end else if (start_div) begin
          state_d  = (b == '0) ? FINISH : DIV;
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, mag_a};
          opnd_d   = mag_b;
          neg_lo_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_hi_d = is_signed & a[WIDTH-1];
          is_div_d = 1'b1;
          dz_d     = (b == '0);
        end
      end
      MULT: begin
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) state_d = FINISH;
      end
      DIV: begin
        if (!sub_diff[WIDTH]) acc_d = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                  acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          dzo_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dzo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dzo_q    <= dzo_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dzo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit : randomized self-checking bench against a 64-bit model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start_mult, start_div, is_signed;
  logic [W-1:0] a, b, hi_out, lo_out;
  logic         busy, done, div_zero;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .is_signed(is_signed), .a(a), .b(b), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0001;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Reference: plain 64-bit integer arithmetic; SV / and % truncate toward zero
  task automatic model(input bit m, input bit d, input bit s,
                       input logic [W-1:0] x, input logic [W-1:0] y, output bit dz);
    longint     sx, sy, r64;
    logic [63:0] v;
    sx = s ? $signed({{32{x[W-1]}}, x}) : $signed({32'b0, x});
    sy = s ? $signed({{32{y[W-1]}}, y}) : $signed({32'b0, y});
    dz = !m && d && (y == '0);
    if (m) begin
      r64 = sx * sy;
      v = r64;
      hi_m = v[63:32];
      lo_m = v[31:0];
    end else if (d && !dz) begin
      r64 = sx / sy;
      v = r64;
      lo_m = v[31:0];
      r64 = sx % sy;
      v = r64;
      hi_m = v[31:0];
    end
  endtask

  task automatic do_op(input bit m, input bit d, input bit s,
                       input logic [W-1:0] x, input logic [W-1:0] y, input int inj);
    bit dz;
    int lat, bcnt, exp_lat;
    model(m, d, s, x, y, dz);
    @(negedge clk);
    start_mult = m; start_div = d; is_signed = s; a = x; b = y;
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0;
    a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      start_mult = (lat == inj);
      @(posedge clk); #1;
      lat++;
    end
    start_mult = 1'b0;
    exp_lat = dz ? 1 : W + 1;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(bcnt), 64'(exp_lat));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("div_zero", 64'(div_zero), 64'(dz));
    chk("hi_out", 64'(hi_out), 64'(hi_m));
    chk("lo_out", 64'(lo_out), 64'(lo_m));
  endtask

  initial begin
    int seen;
    bit m, d;
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; is_signed = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    reset = 1'b0;

    do_op(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("umul_hi_const", 64'(hi_out), 64'hFFFF_FFFE);
    chk("umul_lo_const", 64'(lo_out), 64'h0000_0001);
    do_op(1, 0, 1, 32'hFFFF_FFFD, 32'd7, -1);
    chk("smul_lo_const", 64'(lo_out), 64'hFFFF_FFEB);
    do_op(0, 1, 0, 32'd100, 32'd7, -1);
    chk("udiv_lo_const", 64'(lo_out), 64'd14);
    chk("udiv_hi_const", 64'(hi_out), 64'd2);
    do_op(0, 1, 0, 32'd5, 32'd0, -1);
    chk("dz_hi_const", 64'(hi_out), 64'd2);
    chk("dz_lo_const", 64'(lo_out), 64'd14);
    do_op(0, 1, 1, 32'hFFFF_FFF9, 32'd2, -1);
    chk("sdiv_lo_const", 64'(lo_out), 64'hFFFF_FFFD);
    chk("sdiv_hi_const", 64'(hi_out), 64'hFFFF_FFFF);
    do_op(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("ovf_lo_const", 64'(lo_out), 64'h8000_0000);
    do_op(0, 1, 0, 32'd1000, 32'd33, 5);
    do_op(1, 1, 0, 32'd12, 32'd5, -1);
    chk("both_lo_const", 64'(lo_out), 64'd60);

    // Abort a multiply part way through with reset
    @(negedge clk);
    start_mult = 1'b1; a = 32'd9; b = 32'd9; is_signed = 1'b0;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi_out), 64'd0);
    chk("abort_lo", 64'(lo_out), 64'd0);
    hi_m = '0; lo_m = '0;
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      d = !m || ($urandom_range(0, 3) == 0);
      do_op(m, d, 1'($urandom), pick(),
            ($urandom_range(0, 7) == 0) ? '0 : pick(), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised sequential multiply/divide unit feeding the CPU's HI/LO register pair.
- Driven by the control unit's initMult/initDiv strobes.
- Generalises the fixed 32-bit HI/LO path to WIDTH bits, with signed and unsigned modes and a divide-by-zero flag for the exception logic.
- One iteration per clock: shift-add multiply, restoring divide.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- start_mult  input  1  start multiply; sampled only in IDLE
- start_div  input  1  start divide; sampled only in IDLE
- is_signed  input  1  1 = two's-complement operation, 0 = unsigned; sampled with start
- a  input  WIDTH  multiplicand or dividend; sampled with start
- b  input  WIDTH  multiplier or divisor; sampled with start
- hi_out  output  WIDTH  HI register (product upper half, or remainder)
- lo_out  output  WIDTH  LO register (product lower half, or quotient)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO are updated
- div_zero  output  1  one-cycle pulse, coincident with done, for a divide by zero

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, state=IDLE.
- Reset mid-operation aborts the operation with the same result: all outputs and state return to the reset values.
- States: IDLE, MULT, DIV, FINISH.
- IDLE:
  - start_mult=1 at edge k: latch operands and is_signed; convert to magnitudes if signed; counter=0; go to MULT.
  - Otherwise, start_div=1 at edge k: same latching.
    - If b==0: go to FINISH with the zero flag set.
    - Else: go to DIV.
  - Both starts high: multiply wins; the divide request is dropped.
- MULT/DIV: one iteration per edge. After WIDTH iterations (edge k+WIDTH), go to FINISH.
- FINISH: at the next edge, write HI/LO, pulse done for one cycle, return to IDLE.
- Latency:
  - Normal operation: done is high in the cycle after edge k+WIDTH+1.
  - Divide by zero: done is high in the cycle after edge k+1.
- busy is 1 from edge k through edge k+WIDTH+1, and is 0 in the done cycle.
- A back-to-back start is accepted in the done cycle.
- Starts while busy are ignored; no queuing.
- Multiply:
  - 2*WIDTH-bit product of the magnitudes.
  - If signed and the operand signs differ, negate the 2*WIDTH-bit product.
  - hi_out = product[2W-1:W], lo_out = product[W-1:0].
- Divide (restoring, on magnitudes):
  - lo_out = quotient, hi_out = remainder.
  - Signed: quotient negated when the sign of a differs from the sign of b; remainder takes the sign of a.
  - Signed most-negative / -1: quotient wraps to most-negative, remainder 0. No flag is raised.
- Divide by zero: hi_out and lo_out keep their previous values; div_zero=1 in the done cycle.
- hi_out and lo_out hold between operations; they change only in the done cycle.
- is_signed=0: no magnitude conversion and no sign correction.

Test Plan:
- Unsigned multiply, WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0:
  - hi_out=0xFFFFFFFE, lo_out=0x00000001.
  - done is high exactly 33 cycles after the start edge; busy is high for the 33 cycles before it.
- Signed multiply, a=0xFFFFFFFD (-3), b=7:
  - hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB (-21).
- Divide:
  - Unsigned 100/7: lo_out=14, hi_out=2.
  - Signed 0xFFFFFFF9 (-7) / 2: lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1).
- Divide by zero after the 100/7 result, a=5, b=0:
  - done and div_zero are high in the cycle after the next edge.
  - hi_out=2 and lo_out=14 are unchanged.
  - busy drops to 0 in the done cycle.
- Signed overflow, a=0x80000000, b=0xFFFFFFFF:
  - lo_out=0x80000000, hi_out=0, div_zero=0.
- Robustness:
  - start_mult pulsed 5 cycles into a divide: ignored; the divide result is correct.
  - start_mult and start_div together: multiply result only.
  - reset asserted mid-multiply: next cycle busy=0, hi_out=0, lo_out=0, and done never pulses.
